// File: rtl/key_warm.sv
// Iterative AES-128 key schedule: advances the round key one expansion round per enabled
// cycle and holds the final (round 10) key for the inverse cipher.
module key_warm #(
    parameter int unsigned ROUND_COUNT = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key,
    input  logic         warm_key,
    output logic [127:0] key_round
);

    localparam logic [3:0] RoundMax = 4'(ROUND_COUNT);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd0:    c = 8'h01;
            4'd1:    c = 8'h02;
            4'd2:    c = 8'h04;
            4'd3:    c = 8'h08;
            4'd4:    c = 8'h10;
            4'd5:    c = 8'h20;
            4'd6:    c = 8'h40;
            4'd7:    c = 8'h80;
            4'd8:    c = 8'h1b;
            4'd9:    c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    logic [127:0] key_round_q, key_round_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] src;
    logic [31:0]  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

    // Round 1 expands from the external key; later rounds chain from the register.
    always_comb begin
        src = (rnd_q == 4'd0) ? key : key_round_q;
        w0  = src[127:96];
        w1  = src[95:64];
        w2  = src[63:32];
        w3  = src[31:0];
        rot = {w3[23:0], w3[31:24]};
        sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        t   = sub ^ {rcon(rnd_q), 24'h0};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
    end

    always_comb begin
        key_round_d = key_round_q;
        rnd_d       = rnd_q;
        if (!warm_key) begin
            rnd_d = 4'd0;
        end else if (rnd_q < RoundMax) begin
            key_round_d = {n0, n1, n2, n3};
            rnd_d       = rnd_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_round_q <= '0;
            rnd_q       <= 4'd0;
        end else begin
            key_round_q <= key_round_d;
            rnd_q       <= rnd_d;
        end
    end

    assign key_round = key_round_q;

endmodule

// File: tb/tb_key_warm.sv
// Bench for key_warm: directed FIPS-197 vectors plus random enable/reset/key traffic checked
// against a word-array key-expansion model with an arithmetically derived S-box.
module tb_key_warm;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key;
    logic         warm_key;
    logic [127:0] key_round;

    int unsigned checks = 0;
    int unsigned fails  = 0;

    logic [7:0]   sb [0:255];
    logic [127:0] mdl_out;
    logic [127:0] mdl_start;
    int           mdl_rnd;

    localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    key_warm #(.ROUND_COUNT(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .warm_key  (warm_key),
        .key_round (key_round)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // S-box from its definition: multiplicative inverse in GF(2^8) then the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h01;
            logic [7:0] x = 8'(v);
            for (int i = 0; i < 254; i++) inv = gmul(inv, x);
            sb[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Standard FIPS-197 expansion into 44 words; returns round key n.
    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [0:43];
        logic [7:0]  rc = 8'h01;
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model by the behavioural rules, compare after the edge.
    task automatic step(input logic r, input logic w, input logic [127:0] k);
        rst      = r;
        warm_key = w;
        key      = k;
        @(posedge clk);
        #1;
        if (r) begin
            mdl_out = '0;
            mdl_rnd = 0;
        end else if (!w) begin
            mdl_rnd = 0;
        end else if (mdl_rnd == 0) begin
            mdl_start = k;
            mdl_rnd   = 1;
            mdl_out   = round_key(mdl_start, 1);
        end else if (mdl_rnd < 10) begin
            mdl_rnd++;
            mdl_out = round_key(mdl_start, mdl_rnd);
        end
        chk("model", key_round, mdl_out);
    endtask

    initial begin
        logic [127:0] rk;
        build_sbox();
        mdl_out   = '0;
        mdl_start = '0;
        mdl_rnd   = 0;
        rst = 1'b1; warm_key = 1'b0; key = '0;
        @(negedge clk);

        step(1'b1, 1'b0, FipsKey);
        chk("reset_zero", key_round, 128'h0);

        step(1'b0, 1'b1, FipsKey);
        chk("fips_r1", key_round, FipsR1);
        step(1'b0, 1'b0, FipsKey);
        chk("fips_r1_hold", key_round, FipsR1);

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, FipsKey);
        chk("fips_r10", key_round, FipsR10);
        step(1'b0, 1'b0, 128'h0);
        chk("fips_r10_hold", key_round, FipsR10);

        step(1'b0, 1'b1, 128'h0);
        chk("zero_r1", key_round, ZeroR1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 128'h0);
        chk("zero_r10", key_round, ZeroR10);
        step(1'b0, 1'b0, 128'h0);

        for (int i = 0; i < 15; i++) begin
            // key changes mid-expansion must be ignored
            step(1'b0, 1'b1, (i == 0) ? FipsKey : 128'h0);
            if (i >= 9) chk("fips_saturate", key_round, FipsR10);
        end
        step(1'b0, 1'b0, FipsKey);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, FipsKey);
        rk = round_key(FipsKey, 4);
        step(1'b0, 1'b0, FipsKey);
        chk("abort_partial", key_round, rk);
        step(1'b0, 1'b1, FipsKey);
        chk("restart_r1", key_round, FipsR1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, FipsKey);
        chk("restart_r10", key_round, FipsR10);
        step(1'b0, 1'b0, FipsKey);

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, FipsKey);
        step(1'b1, 1'b1, FipsKey);
        chk("rst_priority", key_round, 128'h0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, FipsKey);
        chk("post_rst_r10", key_round, FipsR10);

        for (int i = 0; i < 300; i++) begin
            logic [127:0] rkey;
            rkey = {$urandom, $urandom, $urandom, $urandom};
            step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 85), rkey);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
